// File: rtl/cardinal_router_pe_port.sv
// Router-side endpoint of the NIC link: owns the ring phase and one
// ping-pong buffer per direction so the NIC and the switch always use opposite VCs.
module cardinal_router_pe_port #(
    parameter int PACKET_SIZE = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   polarity,
    input  logic                   pe_si,
    output logic                   pe_ri,
    input  logic [PACKET_SIZE-1:0] pe_di,
    output logic                   pe_so,
    input  logic                   pe_ro,
    output logic [PACKET_SIZE-1:0] pe_do,
    output logic                   inj_so,
    input  logic                   inj_ro,
    output logic [PACKET_SIZE-1:0] inj_do,
    input  logic                   ej_si,
    output logic                   ej_ri,
    input  logic [PACKET_SIZE-1:0] ej_di,
    output logic                   vc_err,
    output logic [CNT_WIDTH-1:0]   inj_cnt,
    output logic [CNT_WIDTH-1:0]   ej_cnt
);

    logic [1:0][PACKET_SIZE-1:0] inj_buf;
    logic [1:0][PACKET_SIZE-1:0] ej_buf;
    logic [1:0]                  inj_full;
    logic [1:0]                  ej_full;
    logic                        np;
    logic                        inj_wr;
    logic                        ej_wr;
    logic                        ej_rd;

    assign np = ~polarity;

    // Ready is forced low while reset is held, not just implied by empty flags.
    assign pe_ri  = reset && !inj_full[np];
    assign ej_ri  = reset && !ej_full[polarity];

    assign inj_so = inj_full[polarity] && inj_ro;
    assign inj_do = inj_so ? inj_buf[polarity] : '0;
    assign pe_so  = ej_full[np];
    assign pe_do  = pe_so ? ej_buf[np] : '0;

    assign inj_wr = pe_si && pe_ri;
    assign ej_wr  = ej_si && ej_ri;
    assign ej_rd  = pe_so && pe_ro;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity <= 1'b0;
            inj_buf  <= '0;
            ej_buf   <= '0;
            inj_full <= '0;
            ej_full  <= '0;
            vc_err   <= 1'b0;
            inj_cnt  <= '0;
            ej_cnt   <= '0;
        end else begin
            polarity <= np;

            // Writes land on entry ~p (inject) / p (eject); reads use the other one.
            if (inj_wr) begin
                if (pe_di[0] == np) begin
                    inj_buf[np]  <= pe_di;
                    inj_full[np] <= 1'b1;
                end else begin
                    vc_err <= 1'b1;
                end
            end
            if (inj_so) begin
                inj_full[polarity] <= 1'b0;
                if (inj_cnt != '1)
                    inj_cnt <= inj_cnt + 1'b1;
            end

            if (ej_wr) begin
                if (ej_di[0] == polarity) begin
                    ej_buf[polarity]  <= ej_di;
                    ej_full[polarity] <= 1'b1;
                end else begin
                    vc_err <= 1'b1;
                end
            end
            if (ej_rd) begin
                ej_full[np] <= 1'b0;
                if (ej_cnt != '1)
                    ej_cnt <= ej_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cardinal_router_pe_port.sv
// Bench for cardinal_router_pe_port: per-VC packet queues as the reference,
// checked every negedge, plus directed literal checks.
module tb_cardinal_router_pe_port;

    localparam int PS = 64;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          pe_si, pe_ri, pe_so, pe_ro;
    logic [PS-1:0] pe_di, pe_do;
    logic          inj_so, inj_ro;
    logic [PS-1:0] inj_do;
    logic          ej_si, ej_ri;
    logic [PS-1:0] ej_di;
    logic          vc_err;
    logic [CW-1:0] inj_cnt, ej_cnt;

    int compared = 0;
    int mismatched = 0;

    cardinal_router_pe_port #(.PACKET_SIZE(PS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .pe_si(pe_si), .pe_ri(pe_ri), .pe_di(pe_di),
        .pe_so(pe_so), .pe_ro(pe_ro), .pe_do(pe_do),
        .inj_so(inj_so), .inj_ro(inj_ro), .inj_do(inj_do),
        .ej_si(ej_si), .ej_ri(ej_ri), .ej_di(ej_di),
        .vc_err(vc_err), .inj_cnt(inj_cnt), .ej_cnt(ej_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the phase as cycle parity, each VC a packet queue (at most one deep).
    bit            mp;
    logic [PS-1:0] iq [2][$];
    logic [PS-1:0] eq [2][$];
    bit            merr;
    int            icnt, ecnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mp = 0; merr = 0; icnt = 0; ecnt = 0;
            iq[0].delete(); iq[1].delete(); eq[0].delete(); eq[1].delete();
        end else begin
            bit acc_i, acc_e, rd_i, rd_e;
            acc_i = pe_si && iq[!mp].size() == 0;
            acc_e = ej_si && eq[mp].size() == 0;
            rd_i  = iq[mp].size() != 0 && inj_ro;
            rd_e  = eq[!mp].size() != 0 && pe_ro;
            if (rd_i) begin void'(iq[mp].pop_front()); icnt++; end
            if (rd_e) begin void'(eq[!mp].pop_front()); ecnt++; end
            if (acc_i) begin
                if (pe_di[0] == !mp) iq[!mp].push_back(pe_di); else merr = 1;
            end
            if (acc_e) begin
                if (ej_di[0] == mp) eq[mp].push_back(ej_di); else merr = 1;
            end
            mp = !mp;
        end
    end

    task automatic chk(input string name, input logic [PS-1:0] got, input logic [PS-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          e_iso, e_pso;
        logic [PS-1:0] e_ido, e_pdo;
        e_iso = iq[mp].size() != 0 && inj_ro;
        e_pso = eq[!mp].size() != 0;
        e_ido = e_iso ? iq[mp][0] : '0;
        e_pdo = e_pso ? eq[!mp][0] : '0;
        chk("m_polarity", PS'(polarity), PS'(mp));
        chk("m_pe_ri", PS'(pe_ri), PS'(reset && iq[!mp].size() == 0));
        chk("m_ej_ri", PS'(ej_ri), PS'(reset && eq[mp].size() == 0));
        chk("m_inj_so", PS'(inj_so), PS'(e_iso));
        chk("m_inj_do", inj_do, e_ido);
        chk("m_pe_so", PS'(pe_so), PS'(e_pso));
        chk("m_pe_do", pe_do, e_pdo);
        chk("m_vc_err", PS'(vc_err), PS'(merr));
        chk("m_inj_cnt", PS'(inj_cnt), PS'(icnt > CMAX ? CMAX : icnt));
        chk("m_ej_cnt", PS'(ej_cnt), PS'(ecnt > CMAX ? CMAX : ecnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PS-1:0] mk(input logic [PS-2:0] up, input bit vc);
        return {up, vc};
    endfunction

    initial begin
        reset = 0; pe_si = 0; pe_di = '0; pe_ro = 0; inj_ro = 0; ej_si = 0; ej_di = '0;
        repeat (3) tick();
        chk("rst_polarity", PS'(polarity), 0);
        chk("rst_pe_ri", PS'(pe_ri), 0);
        chk("rst_ej_ri", PS'(ej_ri), 0);

        // Inject A1 on VC1 in phase 0, drain to switch in phase 1.
        reset = 1; pe_si = 1; pe_di = 64'hA1;
        #1 chk("t1_pe_ri", PS'(pe_ri), 1);
        chk("t1_pol0", PS'(polarity), 0);
        tick();
        pe_si = 0; inj_ro = 1;
        #1 chk("t1_inj_so", PS'(inj_so), 1);
        chk("t1_inj_do", inj_do, 64'hA1);
        tick();
        inj_ro = 0;
        #1 chk("t1_inj_cnt", PS'(inj_cnt), 1);
        chk("t1_inj_so_off", PS'(inj_so), 0);

        // Phase is 0: a packet with bit0 == 0 is on the wrong VC.
        pe_si = 1; pe_di = 64'h10;
        tick();
        pe_si = 0;
        #1 chk("t2_vc_err", PS'(vc_err), 1);
        chk("t2_pe_ri", PS'(pe_ri), 1);
        repeat (3) tick();
        chk("t2_vc_err_sticky", PS'(vc_err), 1);

        // Fill both injection entries with the switch stalled.
        pe_si = 1; pe_di = mk(63'h111, !mp);
        tick();
        pe_di = mk(63'h222, !mp);
        tick();
        pe_si = 0;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t3_pe_ri_stall", PS'(pe_ri), 0);
            tick();
        end
        inj_ro = 1;
        #1 chk("t3_first_so", PS'(inj_so), 1);
        tick();
        #1 chk("t3_second_so", PS'(inj_so), 1);
        tick();
        inj_ro = 0;
        #1 chk("t3_inj_cnt", PS'(inj_cnt), 3);

        // Ejection of B0 in phase 0 with the NIC stalled.
        if (mp) tick();
        ej_si = 1; ej_di = 64'hB0;
        tick();
        ej_si = 0;
        #1 chk("t4_pe_so_p1", PS'(pe_so), 1);
        chk("t4_pe_do", pe_do, 64'hB0);
        tick();
        #1 chk("t4_pe_so_p0", PS'(pe_so), 0);
        tick();
        #1 chk("t4_pe_do_stable", pe_do, 64'hB0);
        pe_ro = 1;
        tick();
        pe_ro = 0;
        #1 chk("t4_ej_cnt", PS'(ej_cnt), 1);
        tick();
        #1 chk("t4_pe_so_done", PS'(pe_so), 0);

        // Full-rate streaming both ways; counters saturate.
        inj_ro = 1; pe_ro = 1;
        for (int i = 0; i < 20; i++) begin
            pe_si = 1; pe_di = mk(63'(i + 32'h300), !mp);
            ej_si = 1; ej_di = mk(63'(i + 32'h500), mp);
            #1 chk("t5_pe_ri", PS'(pe_ri), 1);
            chk("t5_ej_ri", PS'(ej_ri), 1);
            tick();
        end
        pe_si = 0; ej_si = 0;
        repeat (3) tick();
        chk("t5_inj_sat", PS'(inj_cnt), PS'(CMAX));
        chk("t5_ej_sat", PS'(ej_cnt), PS'(CMAX));

        // Fill all four entries, then reset mid-cycle.
        inj_ro = 0; pe_ro = 0;
        pe_si = 1; ej_si = 1;
        pe_di = mk(63'h7A, !mp); ej_di = mk(63'h7B, mp);
        tick();
        pe_di = mk(63'h7C, !mp); ej_di = mk(63'h7D, mp);
        tick();
        pe_si = 0; ej_si = 0; inj_ro = 1;
        #1 chk("t6_full_pe_ri", PS'(pe_ri), 0);
        chk("t6_full_ej_ri", PS'(ej_ri), 0);
        #1 reset = 0;
        #1 chk("t6_inj_so", PS'(inj_so), 0);
        chk("t6_inj_do", inj_do, 0);
        chk("t6_pe_so", PS'(pe_so), 0);
        chk("t6_pe_do", pe_do, 0);
        chk("t6_pe_ri", PS'(pe_ri), 0);
        chk("t6_ej_ri", PS'(ej_ri), 0);
        chk("t6_polarity", PS'(polarity), 0);
        chk("t6_cnts", PS'({inj_cnt, ej_cnt}), 0);
        chk("t6_vc_err", PS'(vc_err), 0);
        tick(); tick();
        reset = 1; pe_ro = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_inj", PS'(inj_so), 0);
            chk("t6_no_pe", PS'(pe_so), 0);
        end
        chk("t6_pe_ri_rel", PS'(pe_ri), 1);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
